exec_sequencer: RTL and testbench
=================================

EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 Parameter PC_W, default 9, program counter / ROM address width.
REQ-002 Parameter MUL_LAT, default 1, number of EXEC2 cycles for MUL/MLA/MLS; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 run  input  1  start request, sampled in IDLE.
REQ-006 romdata  input  16  instruction word at address pc, valid one cycle after pc changes.
REQ-007 alu_jump  input  1  ALU jump-taken indication.
REQ-008 alu_rout  input  16  ALU result; bits [PC_W-1:0] are the jump target.
REQ-009 pc  output  PC_W  program counter / ROM address.
REQ-010 instr  output  16  latched current instruction, drives the ALU instr input.
REQ-011 alu_en_n  output  1  ALU enable, active-low.
REQ-012 exec2  output  1  second-phase indication to the ALU.
REQ-013 reg_we  output  1  register-file write strobe for Rd.
REQ-014 mem_we  output  1  data-RAM write strobe.
REQ-015 stack_push, stack_pop  output  1 each  stack strobes.
REQ-016 halted  output  1  high in HALT.
REQ-017 state  output  3  current state encoding, for debug.
REQ-018 retired  output  16  retired-instruction count (see Configuration).

Function
REQ-019 States SHALL be IDLE=0, FETCH=1, EXEC1=2, EXEC2=3, HALT=4. Unused encodings SHALL go to IDLE.
REQ-020 In IDLE the block SHALL move to FETCH when run=1 and stay in IDLE otherwise.
REQ-021 FETCH SHALL latch instr<=romdata and move to EXEC1 (one cycle).
REQ-022 op = instr[14:9]; instr[15] SHALL be ignored.
REQ-023 In EXEC1, op=111111 (STP) SHALL move to HALT with pc unchanged and no strobes.
REQ-024 In EXEC1, op in {011100,011101,011110,101010} SHALL move to EXEC2, load the phase counter with MUL_LAT (MUL family) or 1 (LDR), and keep pc unchanged.
REQ-025 In EXEC1, all other ops SHALL complete: pc<=alu_rout[PC_W-1:0] if alu_jump=1, else pc<=pc+1 (modulo 2^PC_W); next state FETCH.
REQ-026 reg_we SHALL pulse for one cycle in EXEC1 for ops 001100-010110, 011000-011010, 011111, 100000-100010, 100100, 100101 and 101001.
REQ-027 In EXEC1, mem_we SHALL pulse for op 101011, stack_push for 101000, and stack_pop for 101001.
REQ-028 Jump ops (000000-001011), NOP (111110) and undefined/reserved ops SHALL assert no strobes and advance pc per REQ-025.
REQ-029 In EXEC2, exec2=1 and the counter SHALL decrement each cycle.
REQ-030 On the EXEC2 cycle with counter=1: reg_we=1, pc<=pc+1, next state FETCH.
REQ-031 alu_en_n SHALL be 0 in EXEC1 and EXEC2, and 1 in IDLE, FETCH and HALT.
REQ-032 exec2 SHALL be 0 outside EXEC2.
REQ-033 All strobes SHALL be combinational from state and instr, high for exactly one cycle per event.
REQ-034 HALT SHALL persist until rst, with run ignored and halted=1.
REQ-035 Jump to pc+1 is legal; wrap from pc=2^PC_W-1 to 0 is legal.

Reset
REQ-036 With rst=1 at a clock edge: state=IDLE, pc=0, instr=0, counter=0, retired=0. rst SHALL have priority over every transition, including mid-EXEC2.
REQ-037 During and after reset all strobes and exec2 SHALL be 0, alu_en_n=1 and halted=0.

Configuration
REQ-038 Macro SEQ_RETIRE_COUNT_EN: when defined, retired SHALL increment by 1 (wrapping at 16 bits) on every cycle that moves to FETCH from EXEC1 or EXEC2; STP SHALL not count.
REQ-039 When SEQ_RETIRE_COUNT_EN is not defined, retired SHALL be constant 0 and no counter register SHALL exist.

Verification
REQ-040 Reset, run=1, ROM[0]=ADD (op 010100) -> FETCH, EXEC1 with reg_we=1, pc=1 after 3 cycles from run.
REQ-041 ROM[1]=JMA with alu_jump=1, alu_rout=0x0005 -> pc=5 and no strobes.
REQ-042 MUL with MUL_LAT=3 -> EXEC2 for 3 cycles with exec2=1, reg_we only on the 3rd, then pc+1.
REQ-043 STR, then PSH, then POP -> mem_we, stack_push, then stack_pop+reg_we, each a single-cycle pulse.
REQ-044 STP -> HALT, halted=1, pc frozen for 20 cycles despite run=1; with SEQ_RETIRE_COUNT_EN, retired equals the non-STP instruction count.
REQ-045 rst asserted during the 2nd EXEC2 cycle of MUL -> next cycle IDLE, pc=0, exec2=0, no reg_we.

Source files
------------

// File: rtl/exec_sequencer.sv
// exec_sequencer: instruction sequencer driving a ROM, an ALU and its strobes.
//
// Each instruction takes FETCH then EXEC1. MUL/MLA/MLS and LDR also spend
// EXEC2 cycles. STP parks the block in HALT until reset.
//
// Parameters:
//   PC_W    - program counter / ROM address width (must be <= 16)
//   MUL_LAT - EXEC2 cycles for the multiply family, 1..15
//
// Ports:
//   clk_i, rst_i       - clock, synchronous active-high reset
//   run_i              - start request, sampled in IDLE
//   romdata_i          - instruction word at pc_o
//   alu_jump_i         - ALU jump-taken indication
//   alu_rout_i         - ALU result, low PC_W bits are the jump target
//   pc_o               - program counter / ROM address
//   instr_o            - latched instruction for the ALU
//   alu_en_n_o         - ALU enable, active-low (EXEC1/EXEC2)
//   exec2_o            - second-phase indication
//   reg_we_o, mem_we_o - register-file / data-RAM write strobes
//   stack_push_o/pop_o - stack strobes
//   halted_o           - high in HALT
//   state_o            - current state, for debug
//   retired_o          - retired-instruction count
//
// Optional feature: define SEQ_RETIRE_COUNT_EN to build the retired-instruction
// counter; otherwise retired_o is tied to zero.

module exec_sequencer #(
  parameter int unsigned PC_W    = 9,
  parameter int unsigned MUL_LAT = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            run_i,
  input  logic [15:0]     romdata_i,
  input  logic            alu_jump_i,
  input  logic [15:0]     alu_rout_i,
  output logic [PC_W-1:0] pc_o,
  output logic [15:0]     instr_o,
  output logic            alu_en_n_o,
  output logic            exec2_o,
  output logic            reg_we_o,
  output logic            mem_we_o,
  output logic            stack_push_o,
  output logic            stack_pop_o,
  output logic            halted_o,
  output logic [2:0]      state_o,
  output logic [15:0]     retired_o
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StFetch = 3'd1;
  localparam logic [2:0] StExec1 = 3'd2;
  localparam logic [2:0] StExec2 = 3'd3;
  localparam logic [2:0] StHalt  = 3'd4;

  localparam logic [PC_W-1:0] PcOne = {{(PC_W-1){1'b0}}, 1'b1};

  logic [2:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     instr_q, instr_d;
  logic [3:0]      cnt_q, cnt_d;

  // Opcode decode; instr[15] is deliberately not part of the opcode.
  logic [5:0] op;
  logic       op_stp, op_mul, op_ldr, op_wr_rd;

  assign op     = instr_q[14:9];
  assign op_stp = (op == 6'b111111);
  assign op_mul = (op == 6'b011100) || (op == 6'b011101) || (op == 6'b011110);
  assign op_ldr = (op == 6'b101010);

  // Ops that write Rd in EXEC1. Multi-cycle ops write Rd at the end of EXEC2.
  always_comb begin
    op_wr_rd = 1'b0;
    if ((op >= 6'b001100) && (op <= 6'b010110)) op_wr_rd = 1'b1;
    if ((op >= 6'b011000) && (op <= 6'b011010)) op_wr_rd = 1'b1;
    if (op == 6'b011111)                        op_wr_rd = 1'b1;
    if ((op >= 6'b100000) && (op <= 6'b100010)) op_wr_rd = 1'b1;
    if ((op == 6'b100100) || (op == 6'b100101)) op_wr_rd = 1'b1;
    if (op == 6'b101001)                        op_wr_rd = 1'b1;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (run_i) state_d = StFetch;
      end
      StFetch: begin
        instr_d = romdata_i;
        state_d = StExec1;
      end
      StExec1: begin
        if (op_stp) begin
          state_d = StHalt;
        end else if (op_mul || op_ldr) begin
          state_d = StExec2;
          cnt_d   = op_ldr ? 4'd1 : 4'(MUL_LAT);
        end else begin
          pc_d    = alu_jump_i ? alu_rout_i[PC_W-1:0] : pc_q + PcOne;
          state_d = StFetch;
        end
      end
      StExec2: begin
        // A count of 0 here is unreachable; treat it as the last cycle so the
        // block can never get stuck.
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          pc_d    = pc_q + PcOne;
          state_d = StFetch;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      pc_q    <= '0;
      instr_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobes depend only on state and the latched instruction.
  always_comb begin
    reg_we_o     = 1'b0;
    mem_we_o     = 1'b0;
    stack_push_o = 1'b0;
    stack_pop_o  = 1'b0;
    exec2_o      = 1'b0;
    if (state_q == StExec1) begin
      reg_we_o     = op_wr_rd;
      mem_we_o     = (op == 6'b101011);
      stack_push_o = (op == 6'b101000);
      stack_pop_o  = (op == 6'b101001);
    end else if (state_q == StExec2) begin
      exec2_o  = 1'b1;
      reg_we_o = (cnt_q == 4'd1);
    end
  end

  assign alu_en_n_o = !((state_q == StExec1) || (state_q == StExec2));
  assign halted_o   = (state_q == StHalt);
  assign pc_o       = pc_q;
  assign instr_o    = instr_q;
  assign state_o    = state_q;

`ifdef SEQ_RETIRE_COUNT_EN
  logic [15:0] retired_q;
  logic        retire;

  // An instruction retires when control returns to FETCH from execution.
  assign retire = (state_d == StFetch) &&
                  ((state_q == StExec1) || (state_q == StExec2));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      retired_q <= '0;
    end else if (retire) begin
      retired_q <= retired_q + 16'd1;
    end
  end

  assign retired_o = retired_q;
`else
  assign retired_o = 16'h0000;
`endif

  // High ALU result bits are not a jump target.
  generate
    if (PC_W < 16) begin : g_rout_unused
      logic unused_rout;
      assign unused_rout = ^alu_rout_i[15:PC_W];
    end
  endgenerate

endmodule

// File: tb/tb_exec_sequencer.sv
module tb_exec_sequencer;

  localparam int unsigned PC_W    = 9;
  localparam int unsigned MUL_LAT = 3;

`ifdef SEQ_RETIRE_COUNT_EN
  localparam bit RetEn = 1'b1;
`else
  localparam bit RetEn = 1'b0;
`endif

  // Flag bits: {reg_we, mem_we, push, pop, exec2, alu_en_n, halted}
  localparam logic [6:0] RW  = 7'b1000000;
  localparam logic [6:0] MW  = 7'b0100000;
  localparam logic [6:0] PU  = 7'b0010000;
  localparam logic [6:0] PO  = 7'b0001000;
  localparam logic [6:0] X2  = 7'b0000100;
  localparam logic [6:0] AEN = 7'b0000010;
  localparam logic [6:0] HL  = 7'b0000001;
  localparam logic [6:0] NOF = 7'b0000000;

  typedef struct packed {
    logic        rst;
    logic        run;
    logic        jump;
    logic [15:0] rout;
    logic [2:0]  st;
    logic [8:0]  pc;
    logic [15:0] instr;
    logic [6:0]  flags;
    logic [15:0] ret;
  } rec_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            run = 1'b0;
  logic [15:0]     romdata;
  logic            alu_jump = 1'b0;
  logic [15:0]     alu_rout = 16'h0;
  logic [PC_W-1:0] pc;
  logic [15:0]     instr;
  logic            alu_en_n, exec2, reg_we, mem_we, stack_push, stack_pop, halted;
  logic [2:0]      state;
  logic [15:0]     retired;

  logic [15:0] rom [0:511];
  assign romdata = rom[pc];

  int checks   = 0;
  int failures = 0;

  rec_t tbl [18];
  rec_t q [$];

  logic [8:0]  m_pc;
  logic [15:0] m_instr;
  logic [15:0] m_ret;

  always #5 clk = ~clk;

  exec_sequencer #(
    .PC_W   (PC_W),
    .MUL_LAT(MUL_LAT)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .run_i       (run),
    .romdata_i   (romdata),
    .alu_jump_i  (alu_jump),
    .alu_rout_i  (alu_rout),
    .pc_o        (pc),
    .instr_o     (instr),
    .alu_en_n_o  (alu_en_n),
    .exec2_o     (exec2),
    .reg_we_o    (reg_we),
    .mem_we_o    (mem_we),
    .stack_push_o(stack_push),
    .stack_pop_o (stack_pop),
    .halted_o    (halted),
    .state_o     (state),
    .retired_o   (retired)
  );

  function automatic rec_t mk(input logic r, input logic rn, input logic j, input logic [15:0] ro,
                              input logic [2:0] st, input logic [8:0] p, input logic [15:0] ins,
                              input logic [6:0] fl, input logic [15:0] rt);
    rec_t x;
    x.rst = r; x.run = rn; x.jump = j; x.rout = ro; x.st = st; x.pc = p;
    x.instr = ins; x.flags = fl; x.ret = rt;
    return x;
  endfunction

  // Register-writing ops in EXEC1, taken straight from the op list.
  function automatic bit writes_rd(input int op);
    return (op >= 12 && op <= 22) || (op >= 24 && op <= 26) || op == 31 ||
           (op >= 32 && op <= 34) || op == 36 || op == 37 || op == 41;
  endfunction

  task automatic cmp(input string where, input string fld, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s %s: got %h expected %h", where, fld, act, exp);
    end
  endtask

  // Drive a record's inputs for one cycle and check the outputs of that cycle.
  task automatic apply(input rec_t r, input string where);
    @(negedge clk);
    rst      = r.rst;
    run      = r.run;
    alu_jump = r.jump;
    alu_rout = r.rout;
    #1;
    cmp(where, "state", 16'(state), 16'(r.st));
    cmp(where, "pc", 16'(pc), 16'(r.pc));
    cmp(where, "instr", instr, r.instr);
    cmp(where, "reg_we", 16'(reg_we), 16'(r.flags[6]));
    cmp(where, "mem_we", 16'(mem_we), 16'(r.flags[5]));
    cmp(where, "stack_push", 16'(stack_push), 16'(r.flags[4]));
    cmp(where, "stack_pop", 16'(stack_pop), 16'(r.flags[3]));
    cmp(where, "exec2", 16'(exec2), 16'(r.flags[2]));
    cmp(where, "alu_en_n", 16'(alu_en_n), 16'(r.flags[1]));
    cmp(where, "halted", 16'(halted), 16'(r.flags[0]));
    cmp(where, "retired", retired, RetEn ? r.ret : 16'h0);
  endtask

  // Instruction-level model: expands the instruction at m_pc into its cycles.
  task automatic plan();
    logic [15:0] w;
    logic [15:0] r;
    logic        j;
    logic [6:0]  fl;
    int          op;
    int          lat;
    q.push_back(mk(1'b0, 1'($urandom), 1'($urandom), 16'($urandom), 3'd1, m_pc, m_instr, AEN,
                   m_ret));
    w       = rom[m_pc];
    op      = int'(w[14:9]);
    m_instr = w;
    j       = 1'($urandom);
    // Bias some targets to the top address so the pc wrap is exercised.
    r  = ($urandom_range(0, 3) == 0) ? (16'($urandom) | 16'h01FF) : 16'($urandom);
    fl = (writes_rd(op) ? RW : NOF) | (op == 43 ? MW : NOF) | (op == 40 ? PU : NOF) |
         (op == 41 ? PO : NOF);
    q.push_back(mk(1'b0, 1'($urandom), j, r, 3'd2, m_pc, w, fl, m_ret));
    if (op == 28 || op == 29 || op == 30 || op == 42) begin
      lat = (op == 42) ? 1 : int'(MUL_LAT);
      for (int i = 1; i <= lat; i++) begin
        q.push_back(mk(1'b0, 1'($urandom), 1'($urandom), 16'($urandom), 3'd3, m_pc, w,
                       X2 | ((i == lat) ? RW : NOF), m_ret));
      end
      m_pc = m_pc + 9'd1;
    end else begin
      m_pc = j ? r[8:0] : m_pc + 9'd1;
    end
    m_ret = m_ret + 16'd1;
  endtask

  task automatic drain(input string where);
    rec_t r;
    while (q.size() > 0) begin
      r = q.pop_front();
      apply(r, where);
    end
  endtask

  initial begin
    for (int a = 0; a < 512; a++) rom[a] = 16'h0000;
    // Directed program; bit 15 of ADD is set and must be ignored.
    rom[0] = 16'hA800;  // ADD
    rom[1] = 16'h0400;  // jump op
    rom[5] = 16'h3800;  // MUL
    rom[6] = 16'h5600;  // STR
    rom[7] = 16'h5000;  // PSH
    rom[8] = 16'h5200;  // POP
    rom[9] = 16'h7E00;  // STP

    tbl[0]  = mk(0, 1, 0, 16'h0000, 3'd0, 9'd0, 16'h0000, AEN, 16'd0);
    tbl[1]  = mk(0, 0, 0, 16'h0000, 3'd1, 9'd0, 16'h0000, AEN, 16'd0);
    tbl[2]  = mk(0, 0, 0, 16'h0003, 3'd2, 9'd0, 16'hA800, RW, 16'd0);
    tbl[3]  = mk(0, 0, 0, 16'h0000, 3'd1, 9'd1, 16'hA800, AEN, 16'd1);
    tbl[4]  = mk(0, 0, 1, 16'h0005, 3'd2, 9'd1, 16'h0400, NOF, 16'd1);
    tbl[5]  = mk(0, 0, 0, 16'h0000, 3'd1, 9'd5, 16'h0400, AEN, 16'd2);
    tbl[6]  = mk(0, 0, 1, 16'h0077, 3'd2, 9'd5, 16'h3800, NOF, 16'd2);
    tbl[7]  = mk(0, 0, 1, 16'h0077, 3'd3, 9'd5, 16'h3800, X2, 16'd2);
    tbl[8]  = mk(0, 0, 0, 16'h0000, 3'd3, 9'd5, 16'h3800, X2, 16'd2);
    tbl[9]  = mk(0, 0, 0, 16'h0000, 3'd3, 9'd5, 16'h3800, X2 | RW, 16'd2);
    tbl[10] = mk(0, 0, 0, 16'h0000, 3'd1, 9'd6, 16'h3800, AEN, 16'd3);
    tbl[11] = mk(0, 0, 0, 16'h0000, 3'd2, 9'd6, 16'h5600, MW, 16'd3);
    tbl[12] = mk(0, 0, 0, 16'h0000, 3'd1, 9'd7, 16'h5600, AEN, 16'd4);
    tbl[13] = mk(0, 0, 0, 16'h0000, 3'd2, 9'd7, 16'h5000, PU, 16'd4);
    tbl[14] = mk(0, 0, 0, 16'h0000, 3'd1, 9'd8, 16'h5000, AEN, 16'd5);
    tbl[15] = mk(0, 0, 0, 16'h0000, 3'd2, 9'd8, 16'h5200, PO | RW, 16'd5);
    tbl[16] = mk(0, 0, 0, 16'h0000, 3'd1, 9'd9, 16'h5200, AEN, 16'd6);
    tbl[17] = mk(0, 1, 0, 16'h0000, 3'd2, 9'd9, 16'h7E00, NOF, 16'd6);

    // Reset values while rst is held
    apply(mk(1, 1, 0, 16'h0, 3'd0, 9'd0, 16'h0, AEN, 16'd0), "reset0");
    apply(mk(1, 1, 1, 16'h0, 3'd0, 9'd0, 16'h0, AEN, 16'd0), "reset1");

    for (int i = 0; i < 18; i++) apply(tbl[i], $sformatf("dir[%0d]", i));

    // HALT holds with run asserted
    for (int i = 0; i < 20; i++) begin
      apply(mk(0, 1, 1, 16'h0033, 3'd4, 9'd9, 16'h7E00, AEN | HL, 16'd6),
            $sformatf("halt[%0d]", i));
    end

    // Random program against the instruction-level model; STP is excluded.
    for (int a = 0; a < 512; a++) begin
      rom[a] = {1'($urandom), 6'($urandom_range(0, 62)), 9'($urandom)};
    end
    apply(mk(1, 0, 0, 16'h0, 3'd4, 9'd9, 16'h7E00, AEN | HL, 16'd6), "rnd_rst0");
    apply(mk(1, 0, 0, 16'h0, 3'd0, 9'd0, 16'h0, AEN, 16'd0), "rnd_rst1");
    m_pc    = 9'd0;
    m_instr = 16'h0;
    m_ret   = 16'h0;
    for (int k = $urandom_range(0, 3); k > 0; k--) begin
      q.push_back(mk(0, 0, 1'($urandom), 16'($urandom), 3'd0, 9'd0, 16'h0, AEN, 16'd0));
    end
    q.push_back(mk(0, 1, 0, 16'h0, 3'd0, 9'd0, 16'h0, AEN, 16'd0));
    drain("rnd_idle");
    for (int n = 0; n < 250; n++) begin
      plan();
      drain($sformatf("rnd[%0d]", n));
    end

    // Reset during the second EXEC2 cycle of an MLA
    rom[m_pc] = 16'h3A00;
    plan();
    q[3].rst = 1'b1;
    void'(q.pop_back());
    q.push_back(mk(0, 0, 0, 16'h0, 3'd0, 9'd0, 16'h0, AEN, 16'd0));
    q.push_back(mk(0, 0, 1, 16'h0, 3'd0, 9'd0, 16'h0, AEN, 16'd0));
    drain("mul_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
